// File: rtl/collatz_pkg.sv
// Shared types and helpers for the Collatz range server and its iterator.
package collatz_pkg;

  localparam int VALUE_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WRITE,
    FINISH
  } state_t;

  // One Collatz step; arithmetic wraps modulo 2^VALUE_BITS.
  function automatic logic [VALUE_BITS-1:0] collatz_step(input logic [VALUE_BITS-1:0] n);
    logic [VALUE_BITS-1:0] result;
    if (n[0]) begin
      result = (n << 1) + n + VALUE_BITS'(1);
    end else begin
      result = n >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/collatz_iter.sv
// Single-value Collatz iterator: one step per clock, reports sequence length.
module collatz_iter
  import collatz_pkg::*;
#(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic [VALUE_BITS-1:0] n,
  output logic                  done,
  output logic [COUNT_BITS-1:0] len
);

  logic                  active_q, active_d;
  logic [VALUE_BITS-1:0] n_q, n_d;
  logic [COUNT_BITS-1:0] len_q, len_d;
  logic                  done_q, done_d;

  // Load on go, then step until n reaches 1 (or 0, which terminates with length 0).
  always_comb begin
    active_d = active_q;
    n_d      = n_q;
    len_d    = len_q;
    done_d   = 1'b0;
    if (go) begin
      active_d = 1'b1;
      n_d      = n;
      len_d    = (n == '0) ? '0 : COUNT_BITS'(1);
    end else if (active_q) begin
      if (n_q <= VALUE_BITS'(1)) begin
        done_d   = 1'b1;
        active_d = 1'b0;
      end else begin
        n_d = collatz_step(n_q);
        if (len_q != '1) begin
          len_d = len_q + COUNT_BITS'(1);
        end
      end
    end
  end

  // Iterator state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      n_q      <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      n_q      <= n_d;
      len_q    <= len_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign len  = len_q;

endmodule

// File: rtl/collatz_range_server.sv
// Evaluates Collatz lengths for a range of consecutive values into a RAM, then serves reads.
module collatz_range_server
  import collatz_pkg::*;
#(
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4,
  parameter int COUNT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [VALUE_BITS-1:0]    start,
  input  logic [RAM_ADDR_BITS-1:0] rd_addr,
  output logic                     done,
  output logic                     busy,
  output logic [COUNT_BITS-1:0]    count
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_INDEX = RAM_ADDR_BITS'(RAM_WORDS - 1);

  state_t                   state_q, state_d;
  logic [VALUE_BITS-1:0]    base_q, base_d;
  logic [RAM_ADDR_BITS-1:0] index_q, index_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic [COUNT_BITS-1:0]    count_q, count_d;

  logic                     ram_we;
  logic [COUNT_BITS-1:0]    ram [RAM_WORDS];

  logic                     iter_go;
  logic [VALUE_BITS-1:0]    iter_n;
  logic                     iter_done;
  logic [COUNT_BITS-1:0]    iter_len;

  assign iter_go = (state_q == LOAD);
  assign iter_n  = base_q + VALUE_BITS'(index_q);

  collatz_iter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_iter (
    .clk  (clk),
    .reset(reset),
    .go   (iter_go),
    .n    (iter_n),
    .done (iter_done),
    .len  (iter_len)
  );

  // Sequencer: walk the index through the range, one iterator run per entry.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    index_d = index_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          base_d  = start;
          index_d = '0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (iter_done) state_d = WRITE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (index_q == LAST_INDEX) begin
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          index_d = index_q + RAM_ADDR_BITS'(1);
          state_d = LOAD;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered read of the result RAM; old data wins on a same-address write.
  always_comb begin
    count_d = ram[rd_addr];
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      index_q <= index_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Result storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[index_q] <= iter_len;
    end
  end

  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_collatz_range_server.sv
// Directed self-checking bench for collatz_range_server.
module tb_collatz_range_server;
  import collatz_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [31:0] start;
  logic [3:0]  rd_addr;
  logic        done;
  logic        busy;
  logic [15:0] count;

  int checkCount = 0;
  int errorCount = 0;

  int exp1[16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};
  int exp5[16] = '{6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5, 13, 21, 21, 8};

  collatz_range_server dut (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .start  (start),
    .rd_addr(rd_addr),
    .done   (done),
    .busy   (busy),
    .count  (count)
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] value);
    @(negedge clk);
    start = value;
    go    = 1'b1;
    @(negedge clk);
    go    = 1'b0;
  endtask

  // Waits for done, checks it is a single-cycle pulse and that busy falls right after.
  task automatic waitForDone(input string tag, input int budget);
    int cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " done seen"}, 32'(done), 32'd1);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, " done width"}, 32'(done), 32'd0);
    checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
  endtask

  task automatic readCheck(input string tag, input logic [3:0] addr, input int expected);
    @(negedge clk);
    rd_addr = addr;
    @(negedge clk);
    checkOutput(tag, 32'(count), 32'(expected));
  endtask

  initial begin
    int cycles;
    reset   = 1'b1;
    go      = 1'b0;
    start   = '0;
    rd_addr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    reset = 1'b0;

    $display("[TB] range starting at 1");
    applyStimulus(32'd1);
    checkOutput("t1 busy after go", 32'(busy), 32'd1);
    waitForDone("t1", 5000);
    for (int i = 0; i < 16; i++) begin
      readCheck($sformatf("t1 addr %0d", i), 4'(i), exp1[i]);
    end

    $display("[TB] range starting at 27");
    applyStimulus(32'd27);
    waitForDone("t2", 5000);
    readCheck("t2 addr 0", 4'd0, 112);
    readCheck("t2 addr 1", 4'd1, 19);
    readCheck("t2 addr 3", 4'd3, 19);

    $display("[TB] range starting at 0");
    applyStimulus(32'd0);
    waitForDone("t3", 5000);
    readCheck("t3 addr 0", 4'd0, 0);
    readCheck("t3 addr 1", 4'd1, 1);
    readCheck("t3 addr 2", 4'd2, 2);

    $display("[TB] go held high across two runs");
    @(negedge clk);
    start = 32'd1;
    go    = 1'b1;
    repeat (20) @(negedge clk);
    go    = 1'b0;
    start = 32'd50;
    @(negedge clk);
    go    = 1'b1;
    @(negedge clk);
    start = 32'd1;
    waitForDone("t4 run1", 5000);
    @(negedge clk);
    checkOutput("t4 restart busy", 32'(busy), 32'd1);
    waitForDone("t4 run2", 5000);
    go = 1'b0;
    readCheck("t4 addr 2", 4'd2, exp1[2]);
    readCheck("t4 addr 8", 4'd8, exp1[8]);
    readCheck("t4 addr 15", 4'd15, exp1[15]);
    checkOutput("t4 idle busy", 32'(busy), 32'd0);

    $display("[TB] reset during run");
    rd_addr = 4'd8;
    applyStimulus(32'd1);
    cycles = 0;
    while (!(dut.state_q == RUN && dut.index_q == 4'd5) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("t5 reached index 5", 32'(cycles < 2000), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5 reset done", 32'(done), 32'd0);
    checkOutput("t5 reset busy", 32'(busy), 32'd0);
    checkOutput("t5 reset count", 32'(count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(32'd5);
    waitForDone("t5", 5000);

    $display("[TB] read sweep");
    @(negedge clk);
    rd_addr = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t6 sweep addr %0d", i - 1), 32'(count), 32'(exp5[i-1]));
      checkOutput($sformatf("t6 sweep busy %0d", i - 1), 32'(busy), 32'd0);
      if (i < 16) rd_addr = 4'(i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
